// File: rtl/param_ram_ctrl.sv
// Parametrised single-port data RAM: byte-lane writes, 1- or 2-cycle read latency,
// one-cycle error pulse, and a post-reset clear sweep that holds ready low.
module param_ram_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 9,
    parameter int DEPTH          = 512,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_byte_en,
    input  logic [DATA_WIDTH-1:0]   i_data_in,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_rvalid,
    output logic                    o_ready,
    output logic                    o_err
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH+1)'(1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;
    localparam logic [0:0] S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_arr_q;
    logic                  r_arr_vld;
    logic                  r_err;

    logic                  w_in_range;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_clr_we;
    logic                  w_err;
    logic [IDXW-1:0]       w_idx;
    logic [IDXW-1:0]       w_clr_idx;

    assign o_ready    = (r_state == S_IDLE);
    assign w_in_range = ({1'b0, i_addr} < L_DEPTH);
    assign w_rd_acc   = o_ready & i_read;
    // Memory writes are gated by reset so a held reset never disturbs contents.
    assign w_wr_acc   = o_ready & i_write & ~i_read & w_in_range & ~i_reset;
    assign w_clr_we   = (r_state == S_CLEAR) & ~i_reset;
    assign w_err      = o_ready & ((i_read & i_write) | ((i_read | i_write) & ~w_in_range));
    assign w_idx      = i_addr[IDXW-1:0];
    assign w_clr_idx  = r_clr_cnt[IDXW-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_RESET;
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + L_ONE;
            if (r_clr_cnt == L_LAST)
                r_state <= S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_acc) begin
            for (int b = 0; b < NBYTES; b++)
                if (i_byte_en[b])
                    r_mem[w_idx][b*8 +: 8] <= i_data_in[b*8 +: 8];
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_arr_q   <= '0;
            r_arr_vld <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_arr_vld <= w_rd_acc;
            r_err     <= w_err;
            if (w_rd_acc)
                r_arr_q <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_rvalid;
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_dout   <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= r_arr_vld;
                    if (r_arr_vld)
                        r_dout <= r_arr_q;
                end
            end
            assign o_data_out = r_dout;
            assign o_rvalid   = r_rvalid;
        end else begin : g_lat1
            assign o_data_out = r_arr_q;
            assign o_rvalid   = r_arr_vld;
        end
    endgenerate

    assign o_err = r_err;
endmodule

// File: tb/tb_param_ram_ctrl.sv
// Bench for param_ram_ctrl: instance A (512 words, latency 1, clear) and B (300 words,
// latency 2, no clear) share stimulus; a word/byte-level model checks both every cycle.
module tb_param_ram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd = 1'b0, wr = 1'b0;
    logic [8:0]  addr = '0;
    logic [3:0]  be   = '0;
    logic [31:0] din  = '0;
    logic [31:0] qa, qb;
    logic rva, rvb, era, erb, rdya, rdyb;

    always #5 clk = ~clk;

    param_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .READ_LATENCY(1),
                     .CLEAR_ON_RESET(1'b1)) u_a (
        .i_clk(clk), .i_reset(rst), .i_read(rd), .i_write(wr), .i_addr(addr),
        .i_byte_en(be), .i_data_in(din), .o_data_out(qa), .o_rvalid(rva),
        .o_ready(rdya), .o_err(era));

    param_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(300), .READ_LATENCY(2),
                     .CLEAR_ON_RESET(1'b0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_read(rd), .i_write(wr), .i_addr(addr),
        .i_byte_en(be), .i_data_in(din), .o_data_out(qb), .o_rvalid(rvb),
        .o_ready(rdyb), .o_err(erb));

    // ---------------- reference model ----------------
    int md[2] = '{512, 300};
    int ml[2] = '{1, 2};
    bit mc[2] = '{1'b1, 1'b0};
    logic [31:0] mm [2][512];
    logic [3:0]  mk [2][512];     // per-byte "value is known" flags
    logic [31:0] e_dout [2];
    logic [3:0]  e_mask [2];
    bit          e_rv [2], e_err [2], e_rdy [2];
    bit          p_v [2];
    logic [31:0] p_d [2];
    logic [3:0]  p_m [2];
    int          since [2];

    int nvec = 0, nbad = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_dout[k] = '0; e_mask[k] = 4'hF; e_rv[k] = 1'b0; e_err[k] = 1'b0;
            p_v[k] = 1'b0; since[k] = 0; e_rdy[k] = !mc[k];
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit rdy, inr, acc;
            logic [31:0] rdat;
            logic [3:0]  rmk;
            rdy  = e_rdy[k];
            inr  = int'(addr) < md[k];
            rdat = inr ? mm[k][addr] : 32'h0;
            rmk  = inr ? mk[k][addr] : 4'hF;
            acc  = rdy && rd;
            e_err[k] = rdy && ((rd && wr) || ((rd || wr) && !inr));
            if (ml[k] == 1) begin
                e_rv[k] = acc;
                if (acc) begin e_dout[k] = rdat; e_mask[k] = rmk; end
            end else begin
                e_rv[k] = p_v[k];
                if (p_v[k]) begin e_dout[k] = p_d[k]; e_mask[k] = p_m[k]; end
                p_v[k] = acc;
                if (acc) begin p_d[k] = rdat; p_m[k] = rmk; end
            end
            if (rdy && wr && !rd && inr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) begin
                        mm[k][addr][b*8 +: 8] = din[b*8 +: 8];
                        mk[k][addr][b] = 1'b1;
                    end
            if (!rdy) begin
                mm[k][since[k]] = '0;
                mk[k][since[k]] = 4'hF;
                since[k]++;
                if (since[k] == md[k]) e_rdy[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] msk);
        nvec++;
        if (((act ^ exp) & msk) !== 32'h0) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        chk("A ready",  {31'b0, rdya}, {31'b0, e_rdy[0]}, '1);
        chk("A rvalid", {31'b0, rva},  {31'b0, e_rv[0]},  '1);
        chk("A err",    {31'b0, era},  {31'b0, e_err[0]}, '1);
        chk("A dout",   qa, e_dout[0], bmask(e_mask[0]));
        chk("B ready",  {31'b0, rdyb}, {31'b0, e_rdy[1]}, '1);
        chk("B rvalid", {31'b0, rvb},  {31'b0, e_rv[1]},  '1);
        chk("B err",    {31'b0, erb},  {31'b0, e_err[1]}, '1);
        chk("B dout",   qb, e_dout[1], bmask(e_mask[1]));
    endtask

    // Inputs change at negedge; model advances at posedge; outputs checked at next negedge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit r, input bit w, input logic [8:0] a,
                         input logic [3:0] e, input logic [31:0] d);
        rd = r; wr = w; addr = a; be = e; din = d;
    endtask

    task automatic rand_req();
        int sel;
        sel  = $urandom_range(0, 7);
        rd   = (sel <= 2) || (sel == 6);
        wr   = (sel >= 3 && sel <= 6);
        addr = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
        be   = 4'($urandom_range(0, 15));
        din  = $urandom;
    endtask

    // ---------------- directed table (instance A, latency 1) ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        bit          xrv;
        logic [31:0] xdout;
        bit          xerr;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int n, noise;
        tbl[0]  = '{1'b0, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 9'h010, 4'h1, 32'h000000AA, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 9'h010, 4'h0, 32'h0,        1'b1, 32'hDEADBEAA, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 9'h1FF, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b1, 9'h020, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b0, 9'h020, 4'h0, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 1'b1, 9'h010, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 9'h010, 4'h0, 32'h0,        1'b1, 32'hDEADBEAA, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 9'h010, 4'hF, 32'h11111111, 1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 9'h010, 4'h0, 32'h0,        1'b1, 32'h11111111, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 9'h010, 4'hA, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b1, 1'b0, 9'h010, 4'h0, 32'h0,        1'b1, 32'hFF11FF11, 1'b0};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 512; i++) begin mm[k][i] = '0; mk[k][i] = 4'h0; end
        model_reset();

        // Reset, then the full clear sweep of A
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (!rdya && n < 600) begin step(); n++; end
        chk("clear length", n, 512, '1);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].din);
            step();
            chk($sformatf("tbl%0d rvalid", i), {31'b0, rva}, {31'b0, tbl[i].xrv}, '1);
            chk($sformatf("tbl%0d err", i),    {31'b0, era}, {31'b0, tbl[i].xerr}, '1);
            if (tbl[i].xrv) chk($sformatf("tbl%0d dout", i), qa, tbl[i].xdout, '1);
        end
        drive(0, 0, 0, 0, 0); step();

        // Latency-2 back-to-back reads on B
        drive(0, 1, 9'h001, 4'hF, 32'hA1A1A1A1); step();
        drive(0, 1, 9'h002, 4'hF, 32'hB2B2B2B2); step();
        drive(0, 1, 9'h003, 4'hF, 32'hC3C3C3C3); step();
        drive(0, 1, 9'h0F0, 4'hF, 32'h0F0F0F0F); step();
        drive(1, 0, 9'h001, 4'h0, 32'h0); step();
        chk("L2 rd1 rvalid", {31'b0, rvb}, 32'd0, '1);
        drive(1, 0, 9'h002, 4'h0, 32'h0); step();
        chk("L2 rd2 rvalid", {31'b0, rvb}, 32'd1, '1);
        chk("L2 rd2 data", qb, 32'hA1A1A1A1, '1);
        drive(1, 0, 9'h003, 4'h0, 32'h0); step();
        chk("L2 rd3 rvalid", {31'b0, rvb}, 32'd1, '1);
        chk("L2 rd3 data", qb, 32'hB2B2B2B2, '1);
        drive(0, 0, 0, 0, 0); step();
        chk("L2 tail rvalid", {31'b0, rvb}, 32'd1, '1);
        chk("L2 tail data", qb, 32'hC3C3C3C3, '1);
        step();
        chk("L2 end rvalid", {31'b0, rvb}, 32'd0, '1);

        // Out-of-range on B (DEPTH 300)
        drive(1, 0, 9'h1F0, 4'h0, 32'h0); step();
        chk("oor rd err", {31'b0, erb}, 32'd1, '1);
        drive(0, 0, 0, 0, 0); step();
        chk("oor rd rvalid", {31'b0, rvb}, 32'd1, '1);
        chk("oor rd data", qb, 32'h0, '1);
        drive(0, 1, 9'h1F0, 4'hF, 32'h55555555); step();
        chk("oor wr err", {31'b0, erb}, 32'd1, '1);
        drive(1, 0, 9'h0F0, 4'h0, 32'h0); step();
        drive(0, 0, 0, 0, 0); step();
        chk("oor wr no alias", qb, 32'h0F0F0F0F, '1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin rand_req(); step(); end

        // Reset partway through a clear, with traffic the whole time
        drive(0, 0, 0, 0, 0);
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 100; i++) begin rand_req(); step(); end
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin rand_req(); step(); end
        rst = 1'b0;
        n = 0; noise = 0;
        while (!rdya && n < 600) begin
            rand_req(); step(); n++;
            if (rva || era) noise++;
        end
        chk("reclear length", n, 512, '1);
        chk("reclear quiet", noise, 0, '1);

        for (int i = 0; i < 200; i++) begin rand_req(); step(); end
        drive(0, 0, 0, 0, 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
